// File: rtl/matrix_stream_pkg.sv
// Shared types and helpers for the matrix output streamer: FSM state encoding
// and the width functions used to size dimension and channel fields.
package matrix_stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    function automatic int dim_w(input int max_dim);
        return $clog2(max_dim + 1);
    endfunction

    // Channel select width, never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_stream_fifo.sv
// Per-channel synchronous FIFO. The head word is read straight from the storage
// registers, so a pop consumes the word visible in the same cycle.
module matrix_stream_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // Full blocks a push even if a pop frees a slot this cycle; empty blocks a
    // pop even if a push lands this cycle.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/matrix_stream_out.sv
// Multi-channel matrix output streamer: per-core FIFOs, round-robin matrix-granular
// arbitration, row/matrix framing. Optional MATRIX_STREAM_POSITION_EN adds {row,col}.
module matrix_stream_out
    import matrix_stream_pkg::*;
#(
    parameter int   DATA_WIDTH = 16,
    parameter int   CHANNELS   = 4,
    parameter int   FIFO_DEPTH = 16,
    parameter int   MAX_DIM    = 16,
    localparam int  DIM_W      = dim_w(MAX_DIM),
    localparam int  CH_W       = sel_w(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]            in_ready,
    input  logic [DIM_W-1:0]               cfg_rows,
    input  logic [DIM_W-1:0]               cfg_cols,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_matrix,
    output logic                           out_matrix_en,
    output logic                           out_matrix_end_row,
    output logic                           out_matrix_end,
`ifdef MATRIX_STREAM_POSITION_EN
    output logic [2*DIM_W-1:0]             out_matrix_position,
`endif
    output logic [CH_W-1:0]                out_matrix_channel
);

    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
        return (d == '0) ? DIM_W'(1) : d;
    endfunction

    logic [CHANNELS-1:0]   fifo_full, fifo_empty, fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_rdata [CHANNELS];

    state_e                state_q, state_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]       lock_q, lock_d;
    logic [DIM_W-1:0]      rows_q, rows_d, cols_q, cols_d;
    logic [DIM_W-1:0]      row_q, row_d, col_q, col_d;
    logic                  last_sent_q, last_sent_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  en_q, en_d;
    logic                  end_row_q, end_row_d;
    logic                  end_q, end_d;
    logic [CH_W-1:0]       chan_q, chan_d;
`ifdef MATRIX_STREAM_POSITION_EN
    logic [2*DIM_W-1:0]    pos_q, pos_d;
`endif

    logic                  hit;
    logic [CH_W-1:0]       hit_ch;
    logic                  out_free, pop, last_col, last_row;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
        matrix_stream_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (in_valid[c]),
            .wdata (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .pop   (fifo_pop[c]),
            .rdata (fifo_rdata[c]),
            .full  (fifo_full[c]),
            .empty (fifo_empty[c])
        );
        assign in_ready[c] = !fifo_full[c];
        assign fifo_pop[c] = pop && (lock_q == CH_W'(c));
    end

    // Round-robin search beginning at the channel after the last completed grant.
    always_comb begin
        logic [CH_W-1:0] cand;
        hit    = 1'b0;
        hit_ch = '0;
        cand   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = CH_W'((int'(rr_ptr_q) + i) % CHANNELS);
            if (!hit && !fifo_empty[cand]) begin
                hit    = 1'b1;
                hit_ch = cand;
            end
        end
    end

    assign out_free = !en_q || out_ready;
    assign last_col = (col_q == cols_q - DIM_W'(1));
    assign last_row = (row_q == rows_q - DIM_W'(1));

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        row_d       = row_q;
        col_d       = col_q;
        last_sent_d = last_sent_q;
        data_d      = data_q;
        en_d        = en_q;
        end_row_d   = end_row_q;
        end_d       = end_q;
        chan_d      = chan_q;
`ifdef MATRIX_STREAM_POSITION_EN
        pos_d       = pos_q;
`endif
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    lock_d      = hit_ch;
                    rows_d      = clamp_dim(cfg_rows);
                    cols_d      = clamp_dim(cfg_cols);
                    row_d       = '0;
                    col_d       = '0;
                    last_sent_d = 1'b0;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (!last_sent_q) begin
                    pop = out_free && !fifo_empty[lock_q];
                    if (pop) begin
                        if (last_col) begin
                            col_d = '0;
                            row_d = row_q + DIM_W'(1);
                            if (last_row) begin
                                last_sent_d = 1'b1;
                            end
                        end else begin
                            col_d = col_q + DIM_W'(1);
                        end
                    end
                end else if (en_q && out_ready) begin
                    // Grant is released only once the final element is taken.
                    state_d     = IDLE;
                    last_sent_d = 1'b0;
                    rr_ptr_d    = (int'(lock_q) == CHANNELS - 1) ? '0 : lock_q + CH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (out_free) begin
            en_d      = pop;
            end_row_d = pop && last_col;
            end_d     = pop && last_col && last_row;
            if (pop) begin
                data_d = fifo_rdata[lock_q];
                chan_d = lock_q;
`ifdef MATRIX_STREAM_POSITION_EN
                pos_d  = {row_q, col_q};
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_q      <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            last_sent_q <= 1'b0;
            data_q      <= '0;
            en_q        <= 1'b0;
            end_row_q   <= 1'b0;
            end_q       <= 1'b0;
            chan_q      <= '0;
`ifdef MATRIX_STREAM_POSITION_EN
            pos_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            row_q       <= row_d;
            col_q       <= col_d;
            last_sent_q <= last_sent_d;
            data_q      <= data_d;
            en_q        <= en_d;
            end_row_q   <= end_row_d;
            end_q       <= end_d;
            chan_q      <= chan_d;
`ifdef MATRIX_STREAM_POSITION_EN
            pos_q       <= pos_d;
`endif
        end
    end

    assign out_matrix         = data_q;
    assign out_matrix_en      = en_q;
    assign out_matrix_end_row = end_row_q;
    assign out_matrix_end     = end_q;
    assign out_matrix_channel = chan_q;
`ifdef MATRIX_STREAM_POSITION_EN
    assign out_matrix_position = pos_q;
`endif

endmodule
